mem_stage_ctrl: RTL and testbench

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

---
 rtl/mem_stage_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl
//
// Purpose:
//   MEM-stage controller for a 5-stage pipeline. ALU results pass to MEM/WB
//   with one cycle of latency. Loads and stores are issued on a
//   request/acknowledge data-memory bus. While an access is outstanding,
//   the upstream pipeline is frozen through 'stall' and bubbles are
//   inserted into MEM/WB.
//
// Optional feature:
//   MEM_TIMEOUT_EN  - when defined, an access watchdog is enabled. If an
//                     access sees no ack for 16 consecutive WAIT cycles, the
//                     controller abandons it, raises the sticky 'mem_err'
//                     output and returns to IDLE.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   alu_out_in          ALU result / memory address from EX/MEM
//   regB_in             store data from EX/MEM
//   rd_in               destination register from EX/MEM
//   RegWrite_in, MemRead_in, MemWrite_in, MemToReg_in
//                       control bits from EX/MEM
//   mem_req, mem_we, mem_addr, mem_wdata
//                       data-memory request (registered)
//   mem_ack, mem_rdata  data-memory completion pulse and read data
//   stall               combinational freeze of PC, IF/ID, ID/EX, EX/MEM
//   wb_data, wb_rd, wb_RegWrite
//                       MEM/WB register outputs
//   mem_err             sticky watchdog error (MEM_TIMEOUT_EN only)
// -----------------------------------------------------------------------------
module mem_stage_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] alu_out_in,
    input  logic [15:0] regB_in,
    input  logic [2:0]  rd_in,
    input  logic        RegWrite_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic        MemToReg_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        stall,
    output logic [15:0] wb_data,
    output logic [2:0]  wb_rd,
    output logic        wb_RegWrite
`ifdef MEM_TIMEOUT_EN
    ,
    output logic        mem_err
`endif
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t      r_state;

    // Memory bus request registers
    logic        r_mem_req;
    logic        r_mem_we;
    logic [15:0] r_mem_addr;
    logic [15:0] r_mem_wdata;

    // Copies of the EX/MEM fields needed to finish the access
    logic [2:0]  r_rd;
    logic        r_regwrite;
    logic        r_memtoreg;

    // MEM/WB register
    logic [15:0] r_wb_data;
    logic [2:0]  r_wb_rd;
    logic        r_wb_regwrite;

    logic        w_mem_op;
    logic        w_timeout;
    logic        w_stall;

`ifdef MEM_TIMEOUT_EN
    logic [3:0]  r_wait_cnt;
    logic        r_mem_err;

    // The counter holds the number of ack-less WAIT cycles already seen,
    // so a value of 15 means the current cycle is the 16th.
    assign w_timeout = (r_wait_cnt == 4'hF);
`else
    assign w_timeout = 1'b0;
`endif

    assign w_mem_op = MemRead_in | MemWrite_in;

    // Stall covers the issuing IDLE cycle and every WAIT cycle that does not
    // finish the access. Completion (ack or watchdog) releases the pipeline
    // in the same cycle so the next instruction advances on that edge.
    always_comb begin
        w_stall = 1'b0;
        if (rst) begin
            case (r_state)
                ST_IDLE: w_stall = w_mem_op;
                ST_WAIT: w_stall = !mem_ack && !w_timeout;
                default: w_stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= 16'h0000;
            r_mem_wdata   <= 16'h0000;
            r_rd          <= 3'd0;
            r_regwrite    <= 1'b0;
            r_memtoreg    <= 1'b0;
            r_wb_data     <= 16'h0000;
            r_wb_rd       <= 3'd0;
            r_wb_regwrite <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            r_wait_cnt    <= 4'h0;
            r_mem_err     <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_mem_op) begin
                        r_mem_req     <= 1'b1;
                        // A combined read+write request is treated as a read
                        r_mem_we      <= MemWrite_in & ~MemRead_in;
                        r_mem_addr    <= alu_out_in;
                        r_mem_wdata   <= regB_in;
                        r_rd          <= rd_in;
                        r_regwrite    <= RegWrite_in;
                        r_memtoreg    <= MemToReg_in;
                        r_wb_regwrite <= 1'b0;
`ifdef MEM_TIMEOUT_EN
                        r_wait_cnt    <= 4'h0;
`endif
                        r_state       <= ST_WAIT;
                    end else begin
                        r_wb_data     <= alu_out_in;
                        r_wb_rd       <= rd_in;
                        r_wb_regwrite <= RegWrite_in;
                    end
                end
                ST_WAIT: begin
                    if (mem_ack) begin
                        r_mem_req     <= 1'b0;
                        r_wb_data     <= r_memtoreg ? mem_rdata : r_mem_addr;
                        r_wb_rd       <= r_rd;
                        r_wb_regwrite <= r_regwrite;
                        r_state       <= ST_IDLE;
                    end else if (w_timeout) begin
                        r_mem_req     <= 1'b0;
                        r_wb_regwrite <= 1'b0;
`ifdef MEM_TIMEOUT_EN
                        r_mem_err     <= 1'b1;
`endif
                        r_state       <= ST_IDLE;
                    end else begin
                        r_wb_regwrite <= 1'b0;
`ifdef MEM_TIMEOUT_EN
                        r_wait_cnt    <= r_wait_cnt + 4'h1;
`endif
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign stall       = w_stall;
    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign wb_data     = r_wb_data;
    assign wb_rd       = r_wb_rd;
    assign wb_RegWrite = r_wb_regwrite;
`ifdef MEM_TIMEOUT_EN
    assign mem_err     = r_mem_err;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_ctrl
//
// Directed testbench for mem_stage_ctrl. A transaction-level model tracks
// the outstanding memory access and the expected MEM/WB contents. A checker
// compares the DUT against that model on every falling edge. Literal
// expectations for the worked examples in the requirements pin the model.
// -----------------------------------------------------------------------------
module tb_mem_stage_ctrl;

`ifdef MEM_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [15:0] alu_out_in;
    logic [15:0] regB_in;
    logic [2:0]  rd_in;
    logic        RegWrite_in;
    logic        MemRead_in;
    logic        MemWrite_in;
    logic        MemToReg_in;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        stall;
    logic [15:0] wb_data;
    logic [2:0]  wb_rd;
    logic        wb_RegWrite;
`ifdef MEM_TIMEOUT_EN
    logic        mem_err;
`endif

    mem_stage_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .alu_out_in  (alu_out_in),
        .regB_in     (regB_in),
        .rd_in       (rd_in),
        .RegWrite_in (RegWrite_in),
        .MemRead_in  (MemRead_in),
        .MemWrite_in (MemWrite_in),
        .MemToReg_in (MemToReg_in),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .stall       (stall),
        .wb_data     (wb_data),
        .wb_rd       (wb_rd),
        .wb_RegWrite (wb_RegWrite)
`ifdef MEM_TIMEOUT_EN
        ,
        .mem_err     (mem_err)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks;
    int n_fail;
    int stall_total;
    bit chk_en;

    // Model: one outstanding access record plus the MEM/WB contents
    bit          m_busy;
    logic [15:0] m_addr, m_wdata;
    logic        m_we, m_rw, m_m2r;
    logic [2:0]  m_rd;
    int          m_waits;
    logic [15:0] m_wb_data;
    logic [2:0]  m_wb_rd;
    logic        m_wb_rw;
    logic        m_err;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic [15:0] a, input logic [15:0] b, input logic [2:0] rd,
                          input logic rw, input logic mr, input logic mw, input logic m2r);
        alu_out_in  = a;
        regB_in     = b;
        rd_in       = rd;
        RegWrite_in = rw;
        MemRead_in  = mr;
        MemWrite_in = mw;
        MemToReg_in = m2r;
    endtask

    task automatic nop();
        set_ex(16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Update the model on each rising edge from the inputs seen at that edge.
    task automatic model_edge();
        if (!rst) begin
            m_busy = 0; m_addr = 0; m_wdata = 0; m_we = 0; m_rw = 0; m_m2r = 0;
            m_rd = 0; m_waits = 0; m_wb_data = 0; m_wb_rd = 0; m_wb_rw = 0; m_err = 0;
        end else if (!m_busy) begin
            if (MemRead_in || MemWrite_in) begin
                m_busy  = 1;
                m_addr  = alu_out_in;
                m_wdata = regB_in;
                m_we    = MemWrite_in && !MemRead_in;
                m_rd    = rd_in;
                m_rw    = RegWrite_in;
                m_m2r   = MemToReg_in;
                m_waits = 0;
                m_wb_rw = 0;
            end else begin
                m_wb_data = alu_out_in;
                m_wb_rd   = rd_in;
                m_wb_rw   = RegWrite_in;
            end
        end else if (mem_ack) begin
            m_busy    = 0;
            m_wb_data = m_m2r ? mem_rdata : m_addr;
            m_wb_rd   = m_rd;
            m_wb_rw   = m_rw;
        end else if (TMO && m_waits == 15) begin
            m_busy  = 0;
            m_wb_rw = 0;
            m_err   = 1;
        end else begin
            m_waits++;
            m_wb_rw = 0;
        end
    endtask

    task automatic check_cycle();
        logic exp_stall;
        if (!rst)
            exp_stall = 1'b0;
        else if (!m_busy)
            exp_stall = MemRead_in | MemWrite_in;
        else
            exp_stall = !(mem_ack || (TMO && m_waits == 15));
        chk("stall", {15'd0, stall}, {15'd0, exp_stall});
        chk("mem_req", {15'd0, mem_req}, {15'd0, m_busy});
        chk("wb_data", wb_data, m_wb_data);
        chk("wb_rd", {13'd0, wb_rd}, {13'd0, m_wb_rd});
        chk("wb_RegWrite", {15'd0, wb_RegWrite}, {15'd0, m_wb_rw});
        if (m_busy) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
            chk("mem_we", {15'd0, mem_we}, {15'd0, m_we});
        end
`ifdef MEM_TIMEOUT_EN
        chk("mem_err", {15'd0, mem_err}, {15'd0, m_err});
`endif
    endtask

    initial begin
        int base;
        n_checks = 0; n_fail = 0; stall_total = 0; chk_en = 0;
        m_busy = 0; m_addr = 0; m_wdata = 0; m_we = 0; m_rw = 0; m_m2r = 0;
        m_rd = 0; m_waits = 0; m_wb_data = 0; m_wb_rd = 0; m_wb_rw = 0; m_err = 0;
        rst = 1'b0; mem_ack = 1'b0; mem_rdata = 16'h0000;
        nop();

        fork
            forever begin
                @(posedge clk);
                model_edge();
            end
            forever begin
                @(negedge clk);
                if (stall === 1'b1) stall_total++;
                if (chk_en) check_cycle();
            end
        join_none

        step(); step();
        chk_en = 1;
        // Reset state
        chk("rst_wb_data", wb_data, 16'h0000);
        chk("rst_wb_rw", {15'd0, wb_RegWrite}, 16'h0000);
        chk("rst_mem_req", {15'd0, mem_req}, 16'h0000);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_stall", {15'd0, stall}, 16'h0000);
        rst = 1'b1;

        // ALU op passes through in one cycle, no stall
        base = stall_total;
        set_ex(16'h1234, 16'h0000, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        nop();
        chk("alu_wb_data", wb_data, 16'h1234);
        chk("alu_wb_rd", {13'd0, wb_rd}, 16'd3);
        chk("alu_wb_rw", {15'd0, wb_RegWrite}, 16'd1);
        step();
        chk("alu_stall_cycles", 16'(stall_total - base), 16'd0);

        // Load with ack in first WAIT cycle, followed by an ALU op
        base = stall_total;
        set_ex(16'h0040, 16'h0000, 3'd5, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        chk("ld_mem_req", {15'd0, mem_req}, 16'd1);
        chk("ld_mem_addr", mem_addr, 16'h0040);
        chk("ld_mem_we", {15'd0, mem_we}, 16'd0);
        set_ex(16'hFFFF, 16'hFFFF, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0); // ignored in WAIT
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        step();
        mem_ack = 1'b0;
        set_ex(16'h0007, 16'h0000, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("ld_wb_data", wb_data, 16'hBEEF);
        chk("ld_wb_rd", {13'd0, wb_rd}, 16'd5);
        chk("ld_wb_rw", {15'd0, wb_RegWrite}, 16'd1);
        chk("ld_req_drop", {15'd0, mem_req}, 16'd0);
        chk("ld_stall_cycles", 16'(stall_total - base), 16'd1);
        step();
        nop();
        chk("b2b_wb_data", wb_data, 16'h0007);
        chk("b2b_wb_rd", {13'd0, wb_rd}, 16'd2);

        // Store, ack in the third WAIT cycle
        base = stall_total;
        set_ex(16'h0010, 16'h00AA, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            set_ex(16'h5555, 16'h3333, 3'd6, 1'b1, 1'b1, 1'b0, 1'b1);
            mem_ack = (i == 2);
            chk("st_mem_we", {15'd0, mem_we}, 16'd1);
            chk("st_mem_wdata", mem_wdata, 16'h00AA);
            chk("st_wb_rw", {15'd0, wb_RegWrite}, 16'd0);
            step();
        end
        mem_ack = 1'b0;
        nop();
        chk("st_stall_cycles", 16'(stall_total - base), 16'd3);
        chk("st_wb_rw_end", {15'd0, wb_RegWrite}, 16'd0);
        chk("st_req_drop", {15'd0, mem_req}, 16'd0);
        step();

        // Read and write both set: treated as a read of the address
        set_ex(16'h0123, 16'h0456, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        chk("rw_mem_we", {15'd0, mem_we}, 16'd0);
        nop();
        mem_ack = 1'b1; mem_rdata = 16'h9999;
        step();
        mem_ack = 1'b0;
        chk("rw_wb_data", wb_data, 16'h0123);
        chk("rw_wb_rd", {13'd0, wb_rd}, 16'd4);

        // Reset during WAIT aborts; a late ack is ignored
        set_ex(16'h0040, 16'h0000, 3'd5, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        rst = 1'b0;
        #1;
        chk("rstw_stall", {15'd0, stall}, 16'd0);
        step();
        chk("rstw_mem_req", {15'd0, mem_req}, 16'd0);
        chk("rstw_wb_data", wb_data, 16'h0000);
        chk("rstw_mem_addr", mem_addr, 16'h0000);
        rst = 1'b1;
        nop();
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        step();
        mem_ack = 1'b0;
        chk("late_ack_req", {15'd0, mem_req}, 16'd0);
        chk("late_ack_wb_data", wb_data, 16'h0000);
        chk("late_ack_wb_rw", {15'd0, wb_RegWrite}, 16'd0);

`ifdef MEM_TIMEOUT_EN
        // Load never acknowledged: watchdog fires on the 16th WAIT cycle
        base = stall_total;
        set_ex(16'h0040, 16'h0000, 3'd5, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        nop();
        for (int i = 0; i < 15; i++) step();
        chk("tmo_req_still", {15'd0, mem_req}, 16'd1);
        chk("tmo_err_before", {15'd0, mem_err}, 16'd0);
        step();
        chk("tmo_req_drop", {15'd0, mem_req}, 16'd0);
        chk("tmo_err", {15'd0, mem_err}, 16'd1);
        chk("tmo_stall_cycles", 16'(stall_total - base), 16'd16);
        set_ex(16'h0007, 16'h0000, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        nop();
        chk("tmo_err_sticky", {15'd0, mem_err}, 16'd1);
        chk("tmo_after_alu", wb_data, 16'h0007);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("tmo_err_cleared", {15'd0, mem_err}, 16'd0);
`else
        // Without the watchdog an access waits indefinitely for its ack
        set_ex(16'h0040, 16'h0000, 3'd5, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        nop();
        for (int i = 0; i < 20; i++) step();
        chk("long_wait_req", {15'd0, mem_req}, 16'd1);
        mem_ack = 1'b1; mem_rdata = 16'hCAFE;
        step();
        mem_ack = 1'b0;
        chk("long_wait_wb_data", wb_data, 16'hCAFE);
`endif
        step();
        step();
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
